// File: rtl/pcie_mst_wr_dma_if.sv
// Payload source stream and master-bus TX FIFO write port of the MWr DMA initiator.
// The master modport is the DMA side; the slave modport is the source/FIFO side.
interface pcie_mst_wr_dma_if;
    logic        src_valid;
    logic [15:0] src_dat;
    logic        src_ready;
    logic        mst_wr_en;
    logic [17:0] mst_din;
    logic        mst_full;

    modport master (
        input  src_valid,
        input  src_dat,
        input  mst_full,
        output src_ready,
        output mst_wr_en,
        output mst_din
    );

    modport slave (
        output src_valid,
        output src_dat,
        output mst_full,
        input  src_ready,
        input  mst_wr_en,
        input  mst_din
    );
endinterface

// File: rtl/pcie_mst_wr_dma.sv
// Posted MWr32 TLP generator: splits a programmed transfer at max payload and 4 KB
// boundaries and streams {sop, eop, halfword} words into the master-bus TX FIFO.
module pcie_mst_wr_dma #(
    parameter int MAX_PAYLOAD_DW = 32
) (
    input  logic                   pcie_clk,
    input  logic                   sys_rst,
    input  logic [7:0]             bus_num,
    input  logic [4:0]             dev_num,
    input  logic [2:0]             func_num,
    input  logic                   start,
    input  logic [29:0]            dst_addr,
    input  logic [15:0]            xfer_len_dw,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            tlp_cnt,
    pcie_mst_wr_dma_if.master      mst
);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        HDR,
        PAYLOAD,
        NEXT,
        DONE
    } state_t;

    localparam logic [10:0] MAX_LEN = 11'(MAX_PAYLOAD_DW);

    state_t      state_q, state_d;
    logic [29:0] addr_q;
    logic [15:0] rem_q;
    logic [10:0] len_q;
    logic [10:0] hw_cnt_q;
    logic [7:0]  tag_q;
    logic [15:0] tlp_cnt_q;

    logic [10:0] room;
    logic [10:0] len_calc;
    logic [15:0] hdr_word;
    logic        hdr_last;
    logic        pay_last;
    logic        hdr_push;
    logic        pay_push;

    // DWORDs left before the next 4 KB page; a TLP may never cross it.
    assign room     = 11'd1024 - {1'b0, addr_q[9:0]};
    assign hdr_last = (hw_cnt_q == 11'd5);
    assign pay_last = (({1'b0, hw_cnt_q} + 12'd1) == {len_q, 1'b0});
    assign busy     = (state_q == CALC) || (state_q == HDR) ||
                      (state_q == PAYLOAD) || (state_q == NEXT);
    assign done     = (state_q == DONE);
    assign tlp_cnt  = tlp_cnt_q;

    always_comb begin
        len_calc = (rem_q > {5'd0, MAX_LEN}) ? MAX_LEN : rem_q[10:0];
        if (room < len_calc) begin
            len_calc = room;
        end
    end

    always_comb begin
        case (hw_cnt_q[2:0])
            3'd0:    hdr_word = 16'h4000;
            3'd1:    hdr_word = {6'b0, len_q[9:0]};
            3'd2:    hdr_word = {bus_num, dev_num, func_num};
            3'd3:    hdr_word = {tag_q, (len_q > 11'd1) ? 4'hF : 4'h0, 4'hF};
            3'd4:    hdr_word = addr_q[29:14];
            default: hdr_word = {addr_q[13:0], 2'b00};
        endcase
    end

    always_comb begin
        state_d       = state_q;
        hdr_push      = 1'b0;
        pay_push      = 1'b0;
        mst.src_ready = 1'b0;
        mst.mst_wr_en = 1'b0;
        mst.mst_din   = 18'd0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (xfer_len_dw != 16'd0) ? CALC : DONE;
                end
            end
            CALC: state_d = HDR;
            HDR: begin
                hdr_push      = !mst.mst_full;
                mst.mst_wr_en = hdr_push;
                mst.mst_din   = {(hw_cnt_q == 11'd0), 1'b0, hdr_word};
                if (hdr_push && hdr_last) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                pay_push      = mst.src_valid && !mst.mst_full;
                mst.src_ready = !mst.mst_full;
                mst.mst_wr_en = pay_push;
                mst.mst_din   = {1'b0, pay_last, mst.src_dat};
                if (pay_push && pay_last) begin
                    state_d = NEXT;
                end
            end
            // remaining is about to drop by len; equal means this was the final TLP
            NEXT:    state_d = (rem_q == {5'd0, len_q}) ? DONE : CALC;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pcie_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            addr_q    <= 30'd0;
            rem_q     <= 16'd0;
            len_q     <= 11'd0;
            hw_cnt_q  <= 11'd0;
            tag_q     <= 8'd0;
            tlp_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start && (xfer_len_dw != 16'd0)) begin
                        addr_q <= dst_addr;
                        rem_q  <= xfer_len_dw;
                    end
                end
                CALC: begin
                    len_q    <= len_calc;
                    hw_cnt_q <= 11'd0;
                end
                HDR: begin
                    if (hdr_push) begin
                        hw_cnt_q <= hdr_last ? 11'd0 : hw_cnt_q + 11'd1;
                    end
                end
                PAYLOAD: begin
                    if (pay_push) begin
                        hw_cnt_q <= hw_cnt_q + 11'd1;
                    end
                end
                NEXT: begin
                    addr_q    <= addr_q + {19'd0, len_q};
                    rem_q     <= rem_q - {5'd0, len_q};
                    tag_q     <= tag_q + 8'd1;
                    tlp_cnt_q <= tlp_cnt_q + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_mst_wr_dma.sv
// Bench for pcie_mst_wr_dma: a transfer-level reference model predicts the FIFO word
// stream, checked over table vectors, random transfers and hand-written corner sequences.
module tb_pcie_mst_wr_dma;

    localparam int         MAX  = 32;
    localparam logic [7:0] BUS  = 8'h12;
    localparam logic [4:0] DEV  = 5'h05;
    localparam logic [2:0] FUNC = 3'h3;

    typedef struct {
        logic [29:0] addr;
        int          len;
        int          mode;
        int          exp_tlps;
    } vec_t;

    logic        pcie_clk = 1'b0;
    logic        sys_rst;
    logic        start;
    logic [29:0] dst_addr;
    logic [15:0] xfer_len_dw;
    logic        busy;
    logic        done;
    logic [15:0] tlp_cnt;

    pcie_mst_wr_dma_if dma_if ();

    pcie_mst_wr_dma #(.MAX_PAYLOAD_DW(MAX)) dut (
        .pcie_clk    (pcie_clk),
        .sys_rst     (sys_rst),
        .bus_num     (BUS),
        .dev_num     (DEV),
        .func_num    (FUNC),
        .start       (start),
        .dst_addr    (dst_addr),
        .xfer_len_dw (xfer_len_dw),
        .busy        (busy),
        .done        (done),
        .tlp_cnt     (tlp_cnt),
        .mst         (dma_if.master)
    );

    always #5 pcie_clk = ~pcie_clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [17:0] cap_q[$];
    logic [17:0] exp_q[$];
    logic [15:0] src_data[4096];
    int          src_idx = 0;
    int          mode = 0;
    int          done_cnt = 0;
    int          full_viol = 0;
    int          cyc = 0;
    int          last_push_cyc = 0;
    int          done_cyc = 0;
    int          tag_m = 0;
    int          cnt_m = 0;
    logic        full_r = 1'b0;
    vec_t        vecs[6];
    int          t2_len[4]  = '{4, 32, 32, 32};
    logic [31:0] t2_addr[4] = '{32'h0000_0FF0, 32'h0000_1000, 32'h0000_1080, 32'h0000_1100};

    // Passive observer: everything the DUT pushes, consumed source halfwords, done pulses.
    always @(negedge pcie_clk) begin
        cyc++;
        if (dma_if.mst_wr_en) begin
            if (dma_if.mst_full) full_viol++;
            cap_q.push_back(dma_if.mst_din);
            last_push_cyc = cyc;
        end
        if (dma_if.src_valid && dma_if.src_ready) src_idx++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Source and FIFO-full behaviour; mode 1 toggles full every cycle and drops valid at random.
    always @(posedge pcie_clk) begin
        #1;
        if (mode == 1) begin
            full_r = ~full_r;
            dma_if.mst_full  = full_r;
            dma_if.src_valid = ($urandom_range(0, 3) != 0);
        end else begin
            dma_if.mst_full  = 1'b0;
            dma_if.src_valid = 1'b1;
        end
        dma_if.src_dat = src_data[src_idx % 4096];
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: TLP stream for a whole transfer from address/length arithmetic.
    task automatic buildExpected(input logic [29:0] a, input int len);
        logic [31:0] byte_a;
        int          rem;
        int          si;
        int          l;
        int          room;
        logic [9:0]  lf;
        logic [7:0]  tg;
        logic        eop;
        byte_a = {a, 2'b00};
        rem    = len;
        si     = 0;
        exp_q.delete();
        while (rem > 0) begin
            l    = (rem > MAX) ? MAX : rem;
            room = 1024 - int'(byte_a[11:2]);
            if (l > room) l = room;
            lf = l[9:0];
            tg = tag_m[7:0];
            exp_q.push_back({2'b10, 16'h4000});
            exp_q.push_back({2'b00, 6'b0, lf});
            exp_q.push_back({2'b00, BUS, DEV, FUNC});
            exp_q.push_back({2'b00, tg, (l > 1) ? 4'hF : 4'h0, 4'hF});
            exp_q.push_back({2'b00, byte_a[31:16]});
            exp_q.push_back({2'b00, byte_a[15:2], 2'b00});
            for (int k = 0; k < 2 * l; k++) begin
                eop = (k == 2 * l - 1);
                exp_q.push_back({1'b0, eop, src_data[si]});
                si++;
            end
            byte_a = byte_a + 32'(4 * l);
            rem    = rem - l;
            tag_m  = (tag_m + 1) % 256;
            cnt_m  = cnt_m + 1;
        end
    endtask

    task automatic doReset();
        @(posedge pcie_clk);
        #1;
        sys_rst = 1'b1;
        repeat (2) @(posedge pcie_clk);
        #1;
        sys_rst = 1'b0;
        tag_m   = 0;
        cnt_m   = 0;
    endtask

    task automatic applyStimulus(input logic [29:0] a, input int len);
        @(posedge pcie_clk);
        #1;
        start       = 1'b1;
        dst_addr    = a;
        xfer_len_dw = len[15:0];
        @(posedge pcie_clk);
        #1;
        start       = 1'b0;
        dst_addr    = 30'($urandom);
        xfer_len_dw = 16'($urandom);
    endtask

    task automatic prepTransfer(input logic [29:0] a, input int len, input int m);
        for (int i = 0; i < 4096; i++) src_data[i] = 16'($urandom);
        src_idx   = 0;
        cap_q.delete();
        done_cnt  = 0;
        full_viol = 0;
        mode      = m;
        buildExpected(a, len);
    endtask

    task automatic finishTransfer(input string name);
        int n;
        int lat;
        for (int c = 0; c < 6000 && done_cnt == 0; c++) @(negedge pcie_clk);
        checkOutput({name, " done_seen"}, 32'(done_cnt > 0), 32'd1);
        repeat (6) @(negedge pcie_clk);
        lat = done_cyc - last_push_cyc;
        checkOutput({name, " done_pulses"}, done_cnt, 1);
        checkOutput({name, " done_latency_ok"}, 32'(lat >= 1 && lat <= 2), 32'd1);
        checkOutput({name, " no_push_while_full"}, full_viol, 0);
        checkOutput({name, " busy_after"}, 32'(busy), 32'd0);
        checkOutput({name, " tlp_cnt"}, 32'(tlp_cnt), 32'(cnt_m % 65536));
        checkOutput({name, " word_count"}, cap_q.size(), exp_q.size());
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s word%0d", name, i), 32'(cap_q[i]), 32'(exp_q[i]));
    endtask

    function automatic int countSop();
        int s = 0;
        foreach (cap_q[i]) if (cap_q[i][17]) s++;
        return s;
    endfunction

    initial begin
        int          p;
        int          sop_pos[$];
        int          c0;
        logic [29:0] ra;
        int          rl;
        int          rm;

        sys_rst          = 1'b1;
        start            = 1'b0;
        dst_addr         = 30'd0;
        xfer_len_dw      = 16'd0;
        dma_if.src_valid = 1'b0;
        dma_if.src_dat   = 16'd0;
        dma_if.mst_full  = 1'b0;

        vecs[0] = '{30'h0400_0000, 4,  0, 1};
        vecs[1] = '{30'h0000_03FC, 100, 1, 4};
        vecs[2] = '{30'h0000_0200, 1,  0, 1};
        vecs[3] = '{30'h0C00_0000, 64, 1, 2};
        vecs[4] = '{30'h0000_03FF, 3,  0, 2};
        vecs[5] = '{30'h0000_07E0, 40, 1, 2};

        doReset();
        @(negedge pcie_clk);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst tlp_cnt", 32'(tlp_cnt), 32'd0);
        checkOutput("rst src_ready", 32'(dma_if.src_ready), 32'd0);
        checkOutput("rst mst_wr_en", 32'(dma_if.mst_wr_en), 32'd0);
        checkOutput("rst mst_din", 32'(dma_if.mst_din), 32'd0);

        // Single 4-DW TLP at byte 0x1000_0000, header words checked against constants.
        prepTransfer(30'h0400_0000, 4, 0);
        applyStimulus(30'h0400_0000, 4);
        finishTransfer("t1");
        checkOutput("t1 size", cap_q.size(), 14);
        if (cap_q.size() >= 14) begin
            checkOutput("t1 hw0", 32'(cap_q[0]), 32'h2_4000);
            checkOutput("t1 hw1", 32'(cap_q[1]), 32'h0_0004);
            checkOutput("t1 hw2", 32'(cap_q[2]), 32'h0_122B);
            checkOutput("t1 hw3", 32'(cap_q[3]), 32'h0_00FF);
            checkOutput("t1 hw4", 32'(cap_q[4]), 32'h0_1000);
            checkOutput("t1 hw5", 32'(cap_q[5]), 32'h0_0000);
            checkOutput("t1 eop_last", 32'(cap_q[13][16]), 32'd1);
            checkOutput("t1 eop_prev", 32'(cap_q[12][16]), 32'd0);
        end
        checkOutput("t1 tlp_cnt_one", 32'(tlp_cnt), 32'd1);

        // 4 KB boundary split from byte 0xFF0, 100 DW.
        doReset();
        prepTransfer(30'h0000_03FC, 100, 0);
        applyStimulus(30'h0000_03FC, 100);
        finishTransfer("t2");
        foreach (cap_q[i]) if (cap_q[i][17]) sop_pos.push_back(i);
        checkOutput("t2 tlps", sop_pos.size(), 4);
        for (int k = 0; k < 4 && k < sop_pos.size(); k++) begin
            p = sop_pos[k];
            if (p + 5 < cap_q.size()) begin
                checkOutput($sformatf("t2 len%0d", k), 32'(cap_q[p + 1][9:0]), t2_len[k]);
                checkOutput($sformatf("t2 addr%0d", k), {cap_q[p + 4][15:0], cap_q[p + 5][15:0]}, t2_addr[k]);
                checkOutput($sformatf("t2 tag%0d", k), 32'(cap_q[p + 3][15:8]), k);
            end
        end

        for (int v = 0; v < 6; v++) begin
            prepTransfer(vecs[v].addr, vecs[v].len, vecs[v].mode);
            applyStimulus(vecs[v].addr, vecs[v].len);
            finishTransfer($sformatf("vec%0d", v));
            checkOutput($sformatf("vec%0d tlps", v), countSop(), vecs[v].exp_tlps);
        end

        for (int r = 0; r < 6; r++) begin
            ra = 30'($urandom);
            rl = $urandom_range(1, 150);
            rm = $urandom_range(0, 1);
            prepTransfer(ra, rl, rm);
            applyStimulus(ra, rl);
            finishTransfer($sformatf("rnd%0d", r));
        end

        // Zero-length start: done next cycle, nothing pushed, counters untouched.
        mode     = 0;
        c0       = cnt_m;
        cap_q.delete();
        done_cnt = 0;
        applyStimulus(30'h0000_1234, 0);
        @(negedge pcie_clk);
        checkOutput("zero done", 32'(done), 32'd1);
        checkOutput("zero busy", 32'(busy), 32'd0);
        @(negedge pcie_clk);
        checkOutput("zero done_drop", 32'(done), 32'd0);
        repeat (4) @(negedge pcie_clk);
        checkOutput("zero pushes", cap_q.size(), 0);
        checkOutput("zero done_pulses", done_cnt, 1);
        checkOutput("zero tlp_cnt", 32'(tlp_cnt), 32'(c0 % 65536));

        // A second start while busy must not disturb the running transfer.
        prepTransfer(30'h0800_0000, 40, 0);
        applyStimulus(30'h0800_0000, 40);
        @(negedge pcie_clk);
        checkOutput("busy_ign busy", 32'(busy), 32'd1);
        repeat (5) @(posedge pcie_clk);
        #1;
        start       = 1'b1;
        dst_addr    = 30'h0000_0123;
        xfer_len_dw = 16'd7;
        @(posedge pcie_clk);
        #1;
        start = 1'b0;
        finishTransfer("busy_ign");

        // Reset in the payload of the second TLP, then a fresh transfer restarts tag/count.
        prepTransfer(30'h0000_1000, 64, 0);
        applyStimulus(30'h0000_1000, 64);
        for (int c = 0; c < 2000 && !(countSop() >= 2 && cap_q.size() >= 86); c++)
            @(negedge pcie_clk);
        checkOutput("rst_mid reached", 32'(countSop() >= 2 && cap_q.size() >= 86), 32'd1);
        @(posedge pcie_clk);
        #1;
        sys_rst = 1'b1;
        @(posedge pcie_clk);
        #1;
        sys_rst = 1'b0;
        @(negedge pcie_clk);
        checkOutput("rst_mid busy", 32'(busy), 32'd0);
        checkOutput("rst_mid done", 32'(done), 32'd0);
        checkOutput("rst_mid tlp_cnt", 32'(tlp_cnt), 32'd0);
        checkOutput("rst_mid src_ready", 32'(dma_if.src_ready), 32'd0);
        checkOutput("rst_mid mst_wr_en", 32'(dma_if.mst_wr_en), 32'd0);
        checkOutput("rst_mid mst_din", 32'(dma_if.mst_din), 32'd0);
        tag_m = 0;
        cnt_m = 0;
        prepTransfer(30'h0000_02A5, 50, 1);
        applyStimulus(30'h0000_02A5, 50);
        finishTransfer("after_rst");
        if (cap_q.size() > 3) checkOutput("after_rst tag0", 32'(cap_q[3][15:8]), 32'd0);
        checkOutput("after_rst tlp_cnt_two", 32'(tlp_cnt), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
